mcu_reset_ctrl: RTL and testbench
=================================

# mcu_reset_ctrl

Reset sequencer for the Cortex-M0 MCU FPGA build, sitting directly downstream of the simulation/global startup reset and upstream of the core, bus fabric and peripherals. It combines the board reset, PLL lock, a push-button and the core's SYSRESETREQ/LOCKUP requests. From these it drives the sequenced PORESETn and HRESETn outputs and records the last reset cause.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked` and `btn_rst_n`. Minimum 2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples needed to accept a button level change.
- `STRETCH_CYCLES`, 8: length of each reset-release stretch. Minimum 1.
- `LOCKUP_RESET_EN`, 1: when 1, LOCKUP causes a system reset.

Ports:
- `clk` in 1: single clock (HCLK domain).
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: asynchronous PLL lock indication.
- `btn_rst_n` in 1: asynchronous, bouncy board button, active-low.
- `sysresetreq` in 1: from core, synchronous to `clk`.
- `lockup` in 1: from core, synchronous to `clk`.
- `poresetn_o` out 1: power-on reset to core and debug, active-low, registered.
- `hresetn_o` out 1: system reset to AHB/APB and core logic, active-low, registered.
- `reset_cause` out 3: last reset cause, sticky.

## Operation
- While `rst` is high:
  - state is `S_POR`, all counters are 0.
  - `poresetn_o` = 0 and `hresetn_o` = 0.
  - `reset_cause` = 3'b001 (POR).
  - The lock synchronizer resets to 0. The button synchronizer and debounced level reset to 1 (released).
- Button debounce: the debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples differ from the current level. Any sample equal to the current level clears the counter. A press event is the debounced 1→0 transition.
- State machine:
  - `S_POR`: `poresetn_o` = 0 and `hresetn_o` = 0. When the synchronized lock is 1, load the counter and go to `S_PO_STR`.
  - `S_PO_STR`: count `STRETCH_CYCLES`, then set `poresetn_o` = 1 and go to `S_H_STR`.
  - `S_H_STR`: `hresetn_o` stays 0. Count `STRETCH_CYCLES`, then set `hresetn_o` = 1 and go to `S_RUN`.
  - `S_RUN`: both resets are released.
  - `S_SYS`: `poresetn_o` = 1 and `hresetn_o` = 0.
    - While `sysresetreq` is held, the counter reloads.
    - After `STRETCH_CYCLES` cycles with the request low, set `hresetn_o` = 1 and go to `S_RUN`.
- Triggers, evaluated in this priority order:
  1. Lock loss (synchronized lock = 0): from any state except `S_POR`, go to `S_POR`. Cause = 3'b010.
  2. Button press: from any state except `S_POR`, go to `S_POR`. Cause = 3'b011.
  3. `sysresetreq`: only in `S_RUN`, go to `S_SYS`. Cause = 3'b100.
  4. `lockup` with `LOCKUP_RESET_EN` = 1: only in `S_RUN`, go to `S_SYS`. Cause = 3'b101.
- `reset_cause` is written only on the transition edge into `S_POR`/`S_SYS`. It survives PORESETn and HRESETn and is cleared to 3'b001 only by `rst`.
- `sysresetreq`/`lockup` outside `S_RUN` are ignored; they do not restart the power-on stretch.
- Lock loss during `S_PO_STR` or `S_H_STR` aborts the stretch; the counter restarts from the next lock.
- Simultaneous triggers: only the highest priority is acted on and recorded.

## Timing
- All outputs are registered. A trigger sampled at edge k changes outputs after edge k.
  - `sysresetreq` high at edge k: `hresetn_o` reads 0 in cycle k+1.
- `pll_locked` latency: a change reaches the FSM after `SYNC_STAGES` edges, so the outputs react after `SYNC_STAGES`+1 edges.
- Power-up timing, with `rst` released at edge 0 and `pll_locked` steady high:
  - synchronized lock = 1 after edge `SYNC_STAGES`.
  - `poresetn_o` rises after edge `SYNC_STAGES`+`STRETCH_CYCLES`.
  - `hresetn_o` rises `STRETCH_CYCLES` edges later.
- Button: a press is recognised `SYNC_STAGES`+`DEBOUNCE_CYCLES` edges after the pin settles low.
- `rst` mid-sequence: the next edge returns to the reset values, whatever the current state.

## Structure
- Package `mcu_reset_pkg` holds:
  - state enum: `S_POR`, `S_PO_STR`, `S_H_STR`, `S_RUN`, `S_SYS`.
  - cause constants: `CAUSE_POR`, `CAUSE_LOCK`, `CAUSE_BTN`, `CAUSE_SYSREQ`, `CAUSE_LOCKUP`.
- Sub-module `mcu_sync_debounce` (params `SYNC_STAGES`, `DEBOUNCE_CYCLES`, `RESET_VAL`):
  - one instance for the button.
  - the `pll_locked` path instantiates it with `DEBOUNCE_CYCLES` = 0, i.e. synchronize only.
- Stretch counter width: $clog2(`STRETCH_CYCLES`+1).

## Test plan
- Power-up, defaults, `pll_locked` = 1 throughout, `rst` released at edge 0 → `poresetn_o` = 1 after edge 10, `hresetn_o` = 1 after edge 18, `reset_cause` = 3'b001.
- In `S_RUN`, `sysresetreq` pulsed 1 cycle at edge k → `hresetn_o` = 0 for cycles k+1..k+8 and 1 after edge k+9. `poresetn_o` stays 1. Cause = 3'b100.
- In `S_RUN`, `pll_locked` dropped at edge k → `poresetn_o` = 0 after edge k+3. Cause = 3'b010. Lock restored → full 8+8 sequence repeats.
- Button bounces with 10-cycle low pulses → no reset. Held low 40 cycles → `poresetn_o` = 0 after edge `SYNC_STAGES`+16 (18) following settle. Cause = 3'b011.
- `sysresetreq` and lock loss at the same edge → `S_POR` entered, cause = 3'b010. `lockup` with `LOCKUP_RESET_EN` = 0 → no reset.
- `rst` asserted during `S_H_STR` → next edge: both outputs 0, cause = 3'b001, counters 0.

Source files
------------

// File: rtl/mcu_reset_pkg.sv
// Shared definitions for the MCU reset sequencer: sequencer state encoding and
// the reset-cause codes reported on reset_cause.
package mcu_reset_pkg;

  typedef enum logic [2:0] {
    S_POR    = 3'd0,  // both resets asserted, waiting for PLL lock
    S_PO_STR = 3'd1,  // PORESETn stretch after lock
    S_H_STR  = 3'd2,  // PORESETn released, HRESETn stretch
    S_RUN    = 3'd3,  // both resets released
    S_SYS    = 3'd4   // system reset only (SYSRESETREQ / LOCKUP)
  } state_e;

  localparam logic [2:0] CAUSE_POR    = 3'b001;
  localparam logic [2:0] CAUSE_LOCK   = 3'b010;
  localparam logic [2:0] CAUSE_BTN    = 3'b011;
  localparam logic [2:0] CAUSE_SYSREQ = 3'b100;
  localparam logic [2:0] CAUSE_LOCKUP = 3'b101;

endpackage

// File: rtl/mcu_sync_debounce.sv
// Multi-stage synchronizer with optional level debounce for a slow async input.
//   clk      : sampling clock
//   rst      : synchronous active-high reset; all stages load RESET_VAL
//   async_i  : asynchronous input pin
//   level_o  : synchronized (and, if DEBOUNCE_CYCLES > 0, debounced) level
//   fall_o   : high in the cycle before level_o falls, so a consumer registering
//              on the same edge reacts together with the level change
// With DEBOUNCE_CYCLES = 0 the block is a plain synchronizer and fall_o is 0.
module mcu_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit RESET_VAL       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= {SYNC_STAGES{RESET_VAL}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_sync_only
    assign level_o = sync_q[SYNC_STAGES-1];
    assign fall_o  = 1'b0;
  end else begin : g_debounce
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // Count consecutive samples that disagree with the accepted level; the
    // level flips on the DEBOUNCE_CYCLES-th one, any agreeing sample restarts.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a variable unassigned and no latch is inferred.
      level_d = level_q;
      cnt_d   = '0;
      if (sample != level_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sample;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        level_q <= RESET_VAL;
        cnt_q   <= '0;
      end else begin
        level_q <= level_d;
        cnt_q   <= cnt_d;
      end
    end

    assign level_o = level_q;
    assign fall_o  = level_q & ~level_d;
  end

endmodule

// File: rtl/mcu_reset_ctrl.sv
// Reset sequencer for the Cortex-M0 MCU FPGA build.
//   clk         : HCLK
//   rst         : synchronous active-high global startup reset
//   pll_locked  : async PLL lock
//   btn_rst_n   : async, bouncy, active-low board reset button
//   sysresetreq : core reset request (clk domain)
//   lockup      : core lockup indication (clk domain)
//   poresetn_o  : registered active-low power-on reset (core + debug)
//   hresetn_o   : registered active-low system reset (bus, peripherals, core)
//   reset_cause : sticky code of the last reset source, cleared only by rst
module mcu_reset_ctrl
  import mcu_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 8,
  parameter bit LOCKUP_RESET_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       btn_rst_n,
  input  logic       sysresetreq,
  input  logic       lockup,
  output logic       poresetn_o,
  output logic       hresetn_o,
  output logic [2:0] reset_cause
);

  localparam int CNT_W = $clog2(STRETCH_CYCLES + 1);

  // Countdown loads; a stretch ends on the edge that finds the counter at 0.
  // The power-on stretch is measured from the edge the synchronized lock went
  // high, one edge before the sequencer can see it, hence one less than the
  // HRESETn stretch. The system stretch counts STRETCH_CYCLES full cycles with
  // the request low after the last request edge, hence one more.
  localparam logic [CNT_W-1:0] LOAD_PO  = (STRETCH_CYCLES > 1) ?
                                          CNT_W'(STRETCH_CYCLES - 2) : '0;
  localparam logic [CNT_W-1:0] LOAD_H   = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_SYS = CNT_W'(STRETCH_CYCLES);

  logic lock_sync;
  logic lock_fall_unused;
  logic btn_level_unused;
  logic btn_press;

  mcu_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(0),
    .RESET_VAL      (1'b0)
  ) u_lock_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(pll_locked),
    .level_o(lock_sync),
    .fall_o (lock_fall_unused)
  );

  mcu_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (1'b1)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .async_i(btn_rst_n),
    .level_o(btn_level_unused),
    .fall_o (btn_press)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             poresetn_q;
  logic             hresetn_q;
  logic [2:0]       cause_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_POR;
      cnt_q      <= '0;
      poresetn_q <= 1'b0;
      hresetn_q  <= 1'b0;
      cause_q    <= CAUSE_POR;
    end else if (state_q != S_POR && !lock_sync) begin
      // Lock loss outranks everything and also aborts any running stretch.
      state_q    <= S_POR;
      cnt_q      <= '0;
      poresetn_q <= 1'b0;
      hresetn_q  <= 1'b0;
      cause_q    <= CAUSE_LOCK;
    end else if (state_q != S_POR && btn_press) begin
      state_q    <= S_POR;
      cnt_q      <= '0;
      poresetn_q <= 1'b0;
      hresetn_q  <= 1'b0;
      cause_q    <= CAUSE_BTN;
    end else begin
      case (state_q)
        S_POR: begin
          if (lock_sync) begin
            if (STRETCH_CYCLES == 1) begin
              // A one-edge power-on stretch ends on the lock-detect edge.
              state_q    <= S_H_STR;
              poresetn_q <= 1'b1;
              cnt_q      <= LOAD_H;
            end else begin
              state_q <= S_PO_STR;
              cnt_q   <= LOAD_PO;
            end
          end
        end
        S_PO_STR: begin
          if (cnt_q == '0) begin
            state_q    <= S_H_STR;
            poresetn_q <= 1'b1;
            cnt_q      <= LOAD_H;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_H_STR: begin
          if (cnt_q == '0) begin
            state_q   <= S_RUN;
            hresetn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_RUN: begin
          if (sysresetreq) begin
            state_q   <= S_SYS;
            hresetn_q <= 1'b0;
            cnt_q     <= LOAD_SYS;
            cause_q   <= CAUSE_SYSREQ;
          end else if (lockup && LOCKUP_RESET_EN) begin
            state_q   <= S_SYS;
            hresetn_q <= 1'b0;
            cnt_q     <= LOAD_SYS;
            cause_q   <= CAUSE_LOCKUP;
          end
        end
        S_SYS: begin
          // A held request keeps the system reset asserted.
          if (sysresetreq) begin
            cnt_q <= LOAD_SYS;
          end else if (cnt_q == '0) begin
            state_q   <= S_RUN;
            hresetn_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= S_POR;
          cnt_q      <= '0;
          poresetn_q <= 1'b0;
          hresetn_q  <= 1'b0;
        end
      endcase
    end
  end

  assign poresetn_o  = poresetn_q;
  assign hresetn_o   = hresetn_q;
  assign reset_cause = cause_q;

endmodule

// File: tb/tb_mcu_reset_ctrl.sv
module tb_mcu_reset_ctrl;

  localparam int SYNC = 2;
  localparam int DEB  = 16;
  localparam int STR  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pll_locked = 1'b1;
  logic btn_rst_n = 1'b1;
  logic sysresetreq = 1'b0;
  logic lockup = 1'b0;

  logic       por_a, hr_a, por_b, hr_b;
  logic [2:0] cause_a, cause_b;

  always #5 clk = ~clk;

  mcu_reset_ctrl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .LOCKUP_RESET_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .btn_rst_n(btn_rst_n),
    .sysresetreq(sysresetreq), .lockup(lockup),
    .poresetn_o(por_a), .hresetn_o(hr_a), .reset_cause(cause_a)
  );

  mcu_reset_ctrl #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .STRETCH_CYCLES(STR), .LOCKUP_RESET_EN(1'b0)
  ) dut_nl (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .btn_rst_n(btn_rst_n),
    .sysresetreq(sysresetreq), .lockup(lockup),
    .poresetn_o(por_b), .hresetn_o(hr_b), .reset_cause(cause_b)
  );

  // Behavioural model: phase plus the absolute edge number at which the
  // current stretch ends, derived from the documented release timings.
  localparam int M_POR = 0, M_PO = 1, M_H = 2, M_RUN = 3, M_SYS = 4;

  typedef struct {
    int         mode;
    int         t_rel;
    logic [2:0] cause;
  } fsm_m_t;

  int     n_vec = 0;
  int     n_bad = 0;
  int     edge_n = 0;
  bit     model_valid = 1'b0;
  bit     pll_hist[$];
  bit     btn_hist[$];
  bit     btn_lvl;
  int     btn_run;
  fsm_m_t m_a, m_b;

  function automatic fsm_m_t fsm_step(fsm_m_t m, bit lock_seen, bit press, bit req,
                                      bit lk, bit lk_en, int n);
    if (m.mode != M_POR && !lock_seen) begin
      m.mode = M_POR; m.cause = 3'b010;
    end else if (m.mode != M_POR && press) begin
      m.mode = M_POR; m.cause = 3'b011;
    end else begin
      case (m.mode)
        M_POR: if (lock_seen) begin m.mode = M_PO; m.t_rel = n + STR - 1; end
        M_PO:  if (n == m.t_rel) begin m.mode = M_H; m.t_rel = n + STR; end
        M_H:   if (n == m.t_rel) m.mode = M_RUN;
        M_RUN: begin
          if (req) begin
            m.mode = M_SYS; m.cause = 3'b100; m.t_rel = n + STR + 1;
          end else if (lk && lk_en) begin
            m.mode = M_SYS; m.cause = 3'b101; m.t_rel = n + STR + 1;
          end
        end
        M_SYS: begin
          if (req) m.t_rel = n + STR + 1;
          else if (n == m.t_rel) m.mode = M_RUN;
        end
        default: ;
      endcase
    end
    return m;
  endfunction

  function automatic logic [4:0] m_out(fsm_m_t m);
    logic por, hr;
    por = (m.mode == M_H) || (m.mode == M_RUN) || (m.mode == M_SYS);
    hr  = (m.mode == M_RUN);
    return {por, hr, m.cause};
  endfunction

  always @(posedge clk) begin
    bit lock_seen, btn_seen, press;
    if (rst) begin
      edge_n = 0;
      model_valid = 1'b1;
      pll_hist.delete();
      btn_hist.delete();
      for (int i = 0; i < SYNC; i++) begin
        pll_hist.push_back(1'b0);
        btn_hist.push_back(1'b1);
      end
      btn_lvl = 1'b1;
      btn_run = 0;
      m_a.mode = M_POR; m_a.t_rel = 0; m_a.cause = 3'b001;
      m_b = m_a;
    end else begin
      edge_n++;
      // Values taken SYNC edges ago are what the sequencer sees now.
      lock_seen = pll_hist[SYNC-1];
      btn_seen  = btn_hist[SYNC-1];
      pll_hist.push_front(pll_locked);
      void'(pll_hist.pop_back());
      btn_hist.push_front(btn_rst_n);
      void'(btn_hist.pop_back());
      press = 1'b0;
      if (btn_seen != btn_lvl) begin
        btn_run++;
        if (btn_run == DEB) begin
          btn_lvl = btn_seen;
          btn_run = 0;
          press = !btn_lvl;
        end
      end else begin
        btn_run = 0;
      end
      m_a = fsm_step(m_a, lock_seen, press, sysresetreq, lockup, 1'b1, edge_n);
      m_b = fsm_step(m_b, lock_seen, press, sysresetreq, lockup, 1'b0, edge_n);
    end
  end

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_lockup_en",  {por_a, hr_a, cause_a}, m_out(m_a));
      check("model_lockup_dis", {por_b, hr_b, cause_b}, m_out(m_b));
    end
  end

  // Wait until just after edge e (edge numbers restart at each rst).
  task automatic goto(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not reach its end, edge %0d", edge_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",    {por_a, hr_a, cause_a}, 5'b00_001);
    check("reset_state_nl", {por_b, hr_b, cause_b}, 5'b00_001);
    rst = 1'b0;

    // Power-up with lock steady high.
    goto(9);  check("pu_e9",  {3'b0, por_a, hr_a}, 5'b00);
    goto(10); check("pu_e10", {3'b0, por_a, hr_a}, 5'b10);
    goto(17); check("pu_e17", {3'b0, por_a, hr_a}, 5'b10);
    goto(18); check("pu_e18", {por_a, hr_a, cause_a}, 5'b11_001);

    // One-cycle SYSRESETREQ sampled at edge 31.
    goto(30); sysresetreq = 1'b1;
    goto(31); sysresetreq = 1'b0;
    check("sys_k",  {por_a, hr_a, cause_a}, 5'b10_100);
    goto(39); check("sys_k8", {3'b0, por_a, hr_a}, 5'b10);
    goto(40); check("sys_k9", {3'b0, por_a, hr_a}, 5'b11);

    // Held request, last high sample at edge 54.
    goto(50); sysresetreq = 1'b1;
    goto(54); sysresetreq = 1'b0;
    goto(62); check("sys_held_62", {4'b0, hr_a}, 5'b0);
    goto(63); check("sys_held_63", {4'b0, hr_a}, 5'b1);

    // LOCKUP: resets only when enabled.
    goto(70); lockup = 1'b1;
    goto(71); lockup = 1'b0;
    check("lockup_en",  {por_a, hr_a, cause_a}, 5'b10_101);
    check("lockup_dis", {por_b, hr_b, cause_b}, 5'b11_100);

    // Lock loss in RUN, then a full re-sequence.
    goto(90);  pll_locked = 1'b0;
    goto(92);  check("lock_k2", {4'b0, por_a}, 5'b1);
    goto(93);  check("lock_k3", {por_a, hr_a, cause_a}, 5'b00_010);
    goto(100); pll_locked = 1'b1;
    goto(110); check("relock_por", {3'b0, por_a, hr_a}, 5'b10);

    // Lock loss during the HRESETn stretch aborts it.
    goto(111); pll_locked = 1'b0;
    goto(113); check("abort_pre",  {3'b0, por_a, hr_a}, 5'b10);
    goto(114); check("abort_post", {por_a, hr_a, cause_a}, 5'b00_010);
    goto(116); pll_locked = 1'b1;
    goto(118); check("abort_118", {3'b0, por_a, hr_a}, 5'b00);
    goto(126); check("abort_por", {3'b0, por_a, hr_a}, 5'b10);
    goto(134); check("abort_h",   {3'b0, por_a, hr_a}, 5'b11);

    // SYSRESETREQ and lock loss reach the sequencer on the same edge.
    goto(150); pll_locked = 1'b0;
    goto(152); sysresetreq = 1'b1;
    goto(153); sysresetreq = 1'b0;
    check("simul", {por_a, hr_a, cause_a}, 5'b00_010);
    goto(155); pll_locked = 1'b1;

    // Bouncing button with 10-cycle low pulses.
    for (int i = 0; i < 3; i++) begin
      goto(180 + 20 * i); btn_rst_n = 1'b0;
      goto(190 + 20 * i); btn_rst_n = 1'b1;
    end
    goto(249); check("bounce", {por_a, hr_a, cause_a}, 5'b11_010);

    // Button held low from edge 250 for 40 cycles.
    goto(250); btn_rst_n = 1'b0;
    goto(267); check("btn_pre",  {4'b0, por_a}, 5'b1);
    goto(268); check("btn_post", {por_a, hr_a, cause_a}, 5'b00_011);

    // Requests outside RUN are ignored.
    goto(270); sysresetreq = 1'b1;
    goto(271); sysresetreq = 1'b0;
    goto(276); check("ign_por", {3'b0, por_a, hr_a}, 5'b10);
    goto(277); lockup = 1'b1;
    goto(278); lockup = 1'b0;
    goto(284); check("ign_h", {por_a, hr_a, cause_a}, 5'b11_011);
    goto(290); btn_rst_n = 1'b1;

    // rst during the HRESETn stretch.
    goto(300); pll_locked = 1'b0;
    goto(305); pll_locked = 1'b1;
    goto(318);
    check("pre_rst_h", {3'b0, por_a, hr_a}, 5'b10);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid",    {por_a, hr_a, cause_a}, 5'b00_001);
    check("rst_mid_nl", {por_b, hr_b, cause_b}, 5'b00_001);
    rst = 1'b0;
    goto(10); check("rpu_e10", {3'b0, por_a, hr_a}, 5'b10);
    goto(18); check("rpu_e18", {por_a, hr_a, cause_a}, 5'b11_001);

    goto(20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
